// File: rtl/add_2bit.sv
// Registered ripple-carry adder: {c_out, sum} = a + b + carry-in, one cycle latency.
// Optional ADD2BIT_CARRY_CHAIN_EN adds a chain input that feeds the previous carry-out back in.
module add_2bit #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADD2BIT_CARRY_CHAIN_EN
    input  logic             chain,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             out_valid_q, out_valid_d;

    logic             carry_in_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    // The chained carry is simply the held c_out: it only changes on accepted operations.
`ifdef ADD2BIT_CARRY_CHAIN_EN
    assign carry_in_eff = chain ? c_out_q : c_in;
`else
    assign carry_in_eff = c_in;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        carry    = '0;
        sum_comb = '0;
        carry[0] = carry_in_eff;
        for (int i = 0; i < WIDTH; i++) begin
            sum_comb[i]  = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    always_comb begin
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sum_comb;
            c_out_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_2bit.sv
// Self-checking bench for add_2bit: directed steps plus random vectors against an arithmetic model.
// Builds with or without ADD2BIT_CARRY_CHAIN_EN.
module tb_add_2bit;

    localparam int W = 2;
`ifdef ADD2BIT_CARRY_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         chain;
    logic [W-1:0] sum;
    logic         c_out;
    logic         out_valid;

    int vectors;
    int miscompares;

    // Reference model state: what the outputs must show after the last edge.
    int unsigned exp_sum;
    int unsigned exp_cout;
    int unsigned exp_valid;

    add_2bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef ADD2BIT_CARRY_CHAIN_EN
        .chain     (chain),
`endif
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned want);
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sum"}, int'(sum), exp_sum);
        check({tag, ".c_out"}, int'(c_out), exp_cout);
        check({tag, ".out_valid"}, int'(out_valid), exp_valid);
    endtask

    // Drive one cycle of inputs, clock it, update the model, and compare.
    task automatic step(input string tag, input int unsigned ta, input int unsigned tb_v,
                        input bit tc, input bit tv, input bit tch);
        int unsigned cin_eff;
        int unsigned total;
        a        = W'(ta);
        b        = W'(tb_v);
        c_in     = tc;
        in_valid = tv;
        chain    = tch;
        @(posedge clk);
        #1;
        vectors++;
        if (tv) begin
            cin_eff   = (CHAIN_EN && tch) ? exp_cout : int'(tc);
            total     = ta + tb_v + cin_eff;
            exp_sum   = total % (1 << W);
            exp_cout  = total / (1 << W);
        end
        exp_valid = tv;
        check_all(tag);
    endtask

    task automatic reset_model();
        exp_sum   = 0;
        exp_cout  = 0;
        exp_valid = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        c_in        = 1'b0;
        chain       = 1'b0;
        reset_model();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        check_all("por");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step("quiet", 0, 0, 1'b0, 1'b0, 1'b0);

        // Single op, then idle hold
        step("single", 0, 1, 1'b0, 1'b1, 1'b0);
        check("single.lit_sum", int'(sum), 1);
        step("hold", 3, 3, 1'b1, 1'b0, 1'b0);
        check("hold.lit_sum", int'(sum), 1);

        // Carry generation and maximum
        step("gen", 2, 3, 1'b0, 1'b1, 1'b0);
        check("gen.lit_cout", int'(c_out), 1);
        step("prop", 1, 1, 1'b1, 1'b1, 1'b0);
        check("prop.lit_sum", int'(sum), 3);
        step("max", 3, 3, 1'b1, 1'b1, 1'b0);
        check("max.lit", {30'd0, c_out, sum}, 7);
        step("zero", 0, 0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle after a nonzero result
        step("pre_rst", 3, 2, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 0, 1'b0, 1'b0, 1'b0);

        // Exhaustive back-to-back sweep
        for (int i = 0; i < (1 << (2 * W + 1)); i++)
            step("sweep", (i >> (W + 1)) % (1 << W), (i >> 1) % (1 << W), i[0], 1'b1, 1'b0);

        // Throughput: alternating valid with changing operands
        for (int i = 0; i < 8; i++)
            step("alt", i % 4, (i + 1) % 4, i[1], i[0] == 1'b0, 1'b0);

`ifdef ADD2BIT_CARRY_CHAIN_EN
        step("chain_op1", 3, 1, 1'b0, 1'b1, 1'b0);
        check("chain_op1.lit", {30'd0, c_out, sum}, 4);
        step("chain_op2", 0, 0, 1'b0, 1'b1, 1'b1);
        check("chain_op2.lit", {30'd0, c_out, sum}, 1);
        step("chain_set", 3, 3, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_model();
        check_all("chain_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("chain_after_rst", 0, 0, 1'b1, 1'b1, 1'b1);
        check("chain_after_rst.lit", {30'd0, c_out, sum}, 0);
`endif

        // Random vectors
        for (int i = 0; i < 300; i++)
            step("rand", $urandom_range((1 << W) - 1), $urandom_range((1 << W) - 1),
                 1'($urandom), ($urandom_range(3) != 0), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
